// File: rtl/gray_count_scheduler.sv
// Round-robin scheduler sharing one Gray-code counter among NREQ requesters.
// Latency: accept in cycle N, ISSUE N+1, capture end of N+2, resp_valid in N+3.
// Backpressure: none downstream; requesters hold req_valid until req_ack pulses.
//
// Ports:
//   clock, reset (async active-low)
//   req_valid/req_op/req_value : per-requester request, op and LOAD operand
//   req_ack                    : one-hot, combinational, asserted in the accept cycle
//   cnt_*                      : counter controls; cnt_value is the counter's Gray output
//   resp_valid/id/data/err     : one-cycle response to the granted requester
//   busy                       : high whenever the FSM is not in IDLE
module gray_count_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_value,
  output logic [NREQ-1:0]       req_ack,
  output logic                  cnt_enable,
  output logic                  cnt_load,
  output logic                  cnt_hold,
  output logic                  cnt_count_up,
  output logic                  cnt_count_down,
  output logic [WIDTH-1:0]      cnt_start_value,
  input  logic [WIDTH-1:0]      cnt_value,
  output logic                  resp_valid,
  output logic [2:0]            resp_id,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  resp_err,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  logic [1:0]       state;
  logic [2:0]       ptr;
  logic [2:0]       gnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] operand_q;
  logic [WIDTH-1:0] last_value;
  logic [WIDTH-1:0] start_hold;
  logic [WIDTH-1:0] resp_data_q;
  logic             resp_err_q;

  // Rotating priority search: first set req_valid bit at or above ptr, with wrap.
  logic       found;
  logic [2:0] pick;
  int         idx;

  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = 3'(idx);
      end
    end
  end

  logic [WIDTH-1:0] start_sel;
  logic             is_issue;
  logic             step_err;

  assign is_issue  = (state == ST_ISSUE);
  assign start_sel = (op_q == OP_LOAD) ? operand_q : last_value;
  // A legal Gray step flips exactly one bit; anything else on UP/DOWN is an error.
  assign step_err  = ((op_q == OP_UP) || (op_q == OP_DOWN)) &&
                     ($countones(cnt_value ^ last_value) != 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      ptr         <= 3'd0;
      gnt         <= 3'd0;
      op_q        <= OP_LOAD;
      operand_q   <= '0;
      last_value  <= '0;
      start_hold  <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            gnt       <= pick;
            op_q      <= req_op[2*int'(pick) +: 2];
            operand_q <= req_value[WIDTH*int'(pick) +: WIDTH];
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Keep the driven start value visible after the ISSUE cycle.
          start_hold <= start_sel;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          resp_data_q <= cnt_value;
          resp_err_q  <= step_err;
          last_value  <= cnt_value;
          state       <= ST_RESP;
        end
        default: begin
          ptr   <= (gnt == 3'(NREQ - 1)) ? 3'd0 : gnt + 3'd1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    req_ack = '0;
    if (state == ST_IDLE && found) req_ack[pick] = 1'b1;
  end

  assign cnt_enable      = is_issue;
  assign cnt_load        = is_issue && (op_q == OP_LOAD);
  assign cnt_count_up    = is_issue && (op_q == OP_UP);
  assign cnt_count_down  = is_issue && (op_q == OP_DOWN);
  assign cnt_hold        = is_issue && (op_q == OP_READ);
  assign cnt_start_value = is_issue ? start_sel : start_hold;

  assign resp_valid = (state == ST_RESP);
  assign resp_id    = (state == ST_RESP) ? gnt : 3'd0;
  assign resp_data  = resp_data_q;
  assign resp_err   = (state == ST_RESP) && resp_err_q;
  assign busy       = (state != ST_IDLE);

endmodule

// File: doc/gray_count_scheduler.md
# gray_count_scheduler

Round-robin scheduler that shares one 4-bit Gray-code counter among several requesters. Each requester posts an operation (load, count up, count down, read) with an operand. The block grants one requester at a time, sequences the counter control strobes, captures the counter output and returns it to the granted requester with an error flag. It sits between the requester ports and the counter's load/hold/count_up/count_down/enable inputs.

## Interface
- WIDTH, 4: counter data width.
- NREQ, 4: number of requesters (2..8).
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request pending; held until acked.
- req_op  input  2*NREQ  op for requester i in bits [2i+1:2i]: 00 LOAD, 01 UP, 10 DOWN, 11 READ.
- req_value  input  WIDTH*NREQ  operand for requester i in [WIDTH*i +: WIDTH]; used by LOAD only.
- req_ack  output  NREQ  one-hot; pulses in the cycle the request is accepted.
- cnt_enable  output  1  counter enable.
- cnt_load, cnt_hold, cnt_count_up, cnt_count_down  output  1 each  one-hot counter controls.
- cnt_start_value  output  WIDTH  counter start_value.
- cnt_value  input  WIDTH  counter out_value, in Gray code.
- resp_valid  output  1  one-cycle response strobe.
- resp_id  output  3  index of the requester that owns the response.
- resp_data  output  WIDTH  captured counter value.
- resp_err  output  1  Gray-step violation on UP or DOWN.
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. The sequence is fixed; there is no stall.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching upward (with wrap) from the priority pointer `ptr`.
  - req_ack[g] is combinational, asserted in this cycle only.
  - At the clock edge, latch g, op and operand, and go to ISSUE.
  - If no req_valid bit is set, stay in IDLE with all outputs idle.
- ISSUE (one cycle):
  - cnt_enable=1.
  - Exactly one control strobe is high. LOAD -> cnt_load. UP -> cnt_count_up. DOWN -> cnt_count_down. READ -> cnt_hold.
  - cnt_start_value = latched operand for LOAD, otherwise the last captured value.
- WAIT (one cycle):
  - All strobes low; cnt_enable=0.
  - At the clock edge, capture cnt_value into resp_data.
  - Compute resp_err = (op is UP or DOWN) and (popcount(cnt_value ^ last_value) != 1).
  - Set last_value = cnt_value.
- RESP (one cycle):
  - resp_valid=1, resp_id=g, resp_data and resp_err valid.
  - At the clock edge, ptr = (g+1) mod NREQ, and the state returns to IDLE.
- Outside ISSUE, all cnt_* strobes are 0 and cnt_start_value holds its last value.
- Fairness: a continuously asserted requester is granted at least once every NREQ transactions.
- req_valid bits above NREQ-1 do not exist. A requester that drops req_valid before being acked is simply skipped; there is no error.

## Timing
- Reset (asynchronous, active-low):
  - state=IDLE, ptr=0, last_value=0.
  - Outputs: req_ack=0, every cnt_* output=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, busy=0.
- Reset mid-transaction: the in-flight transaction is dropped. No resp_valid is produced and ptr returns to 0.
- Latency: a request accepted in cycle N gets ISSUE in N+1, capture at the end of N+2, and resp_valid in N+3.
- Throughput: one transaction per 4 cycles. The next accept can happen in cycle N+4.
- A req_valid rising during ISSUE, WAIT or RESP waits for IDLE. It is arbitrated against the ptr value that is in effect when IDLE is re-entered.
- When all NREQ requesters assert simultaneously, grants go ptr, ptr+1, ... with wrap, with no repeats within a round.
- The counter must register its result at the ISSUE edge and present it by WAIT. The scheduler adds no bypass path.

## Test plan
- Reset, then req_valid[0] with LOAD 4'b0101 -> req_ack[0] in cycle 0; cnt_load=1 and cnt_start_value=0101 in cycle 1; in cycle 3, resp_valid=1, resp_id=0, resp_data=counter output, resp_err=0.
- All four requesters assert from reset -> grant order 0,1,2,3,0; req_ack pulses spaced exactly 4 cycles apart; ptr wraps correctly.
- UP with a counter model that steps 0001->0011 -> resp_err=0. Force the counter to 0001->0111 -> resp_err=1.
- READ -> only cnt_hold is high in ISSUE, resp_data equals the previous value, and resp_err=0 even when the value is unchanged.
- Assert reset during WAIT -> all outputs are 0 immediately. No resp_valid is produced. The next grant starts from requester 0.
- req_valid[2] asserted during RESP of requester 1 -> it is accepted in the following IDLE cycle with req_ack[2]; requesters 3 and 0 are idle.
